// File: rtl/stage4_mem_pkg.sv
// MEM stage shared definitions: FSM encoding, timeout default, datapath widths.
package stage4_mem_pkg;
   localparam int W           = 32;
   localparam int RW          = 5;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;
endpackage

// File: rtl/stage4_mem_fsm.sv
// Data memory handshake controller: request, wait on ack, abort on timeout.
module mem_access_fsm
   import stage4_mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic access,
   input  logic we,
   input  logic dm_ack,
   output logic dm_req,
   output logic dm_we,
   output logic stall,
   output logic complete,
   output logic abort
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   mem_state_t    state, state_n;
   logic [CW-1:0] cnt, cnt_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      dm_req   = 1'b0;
      stall    = 1'b0;
      complete = 1'b0;
      abort    = 1'b0;
      unique case (state)
         IDLE: begin
            if (access) begin
               dm_req = 1'b1;
               if (dm_ack) begin
                  complete = 1'b1;
               end else begin
                  state_n = WAIT;
                  stall   = 1'b1;
                  cnt_n   = CW'(1);
               end
            end
         end
         WAIT: begin
            dm_req = 1'b1;
            if (dm_ack) begin
               complete = 1'b1;
               state_n  = IDLE;
               cnt_n    = '0;
            end else if (cnt == LAST) begin
               // the final request cycle gives up and releases the pipeline
               abort   = 1'b1;
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               stall = 1'b1;
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      dm_we = we & dm_req;
   end
endmodule

// File: rtl/stage4_mem.sv
// MIPS stage 4: branch resolve, data memory access, MEM/WB pipeline register.
module stage4_mem
   import stage4_mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          branch,
   input  logic          memread,
   input  logic          memwrite,
   input  logic          memtoreg,
   input  logic          regwrite,
   input  logic [W-1:0]  baddr,
   input  logic [W-1:0]  alurslt,
   input  logic          zero,
   input  logic [W-1:0]  data2,
   input  logic [RW-1:0] wrreg,
   output logic          pcsrc,
   output logic [W-1:0]  baddr_out,
   output logic          stall,
   output logic          dm_req,
   output logic          dm_we,
   output logic [W-1:0]  dm_addr,
   output logic [W-1:0]  dm_wdata,
   input  logic [W-1:0]  dm_rdata,
   input  logic          dm_ack,
   output logic          misalign,
   output logic          bus_err,
   output logic          regwrite_out,
   output logic          memtoreg_out,
   output logic [W-1:0]  rdata_out,
   output logic [W-1:0]  alurslt_out,
   output logic [RW-1:0] wrreg_out
);
   logic memop, misalign_now, access;
   logic complete, abort;

   assign memop        = memread | memwrite;
   assign misalign_now = memop & (alurslt[1:0] != 2'b00);
   assign access       = memop & (alurslt[1:0] == 2'b00);

   assign pcsrc     = branch & zero;
   assign baddr_out = baddr;
   assign dm_addr   = alurslt;
   assign dm_wdata  = data2;

   // memwrite alone decides direction, so read+write acts as a store
   mem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
      .clk      (clk),
      .reset    (reset),
      .access   (access),
      .we       (memwrite),
      .dm_ack   (dm_ack),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .stall    (stall),
      .complete (complete),
      .abort    (abort)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         misalign     <= 1'b0;
         bus_err      <= 1'b0;
         regwrite_out <= 1'b0;
         memtoreg_out <= 1'b0;
         rdata_out    <= '0;
         alurslt_out  <= '0;
         wrreg_out    <= '0;
      end else begin
         misalign <= misalign_now & ~stall;
         bus_err  <= abort;
         if (stall) begin
            regwrite_out <= 1'b0;
         end else begin
            regwrite_out <= regwrite & ~abort & ~misalign_now;
            memtoreg_out <= memtoreg;
            alurslt_out  <= alurslt;
            wrreg_out    <= wrreg;
            if (complete) rdata_out <= dm_rdata;
         end
      end
   end
endmodule

// File: tb/tb_stage4_mem.sv
// Randomized transaction-level check of stage4_mem against an ack-delay model.
module tb_stage4_mem;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        branch, memread, memwrite, memtoreg, regwrite, zero;
   logic [31:0] baddr, alurslt, data2, dm_rdata;
   logic [4:0]  wrreg;
   logic        dm_ack;
   logic        pcsrc, stall, dm_req, dm_we, misalign, bus_err;
   logic        regwrite_out, memtoreg_out;
   logic [31:0] baddr_out, dm_addr, dm_wdata, rdata_out, alurslt_out;
   logic [4:0]  wrreg_out;

   int errs = 0;
   int checks = 0;
   logic [31:0] exp_rdata = '0;

   always #5 clk = ~clk;

   stage4_mem #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .branch(branch), .memread(memread),
      .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite),
      .baddr(baddr), .alurslt(alurslt), .zero(zero), .data2(data2),
      .wrreg(wrreg), .pcsrc(pcsrc), .baddr_out(baddr_out), .stall(stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .misalign(misalign), .bus_err(bus_err),
      .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out),
      .rdata_out(rdata_out), .alurslt_out(alurslt_out),
      .wrreg_out(wrreg_out)
   );

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      branch = 0; memread = 0; memwrite = 0; memtoreg = 0;
      regwrite = 0; zero = 0; baddr = '0; alurslt = '0;
      data2 = '0; wrreg = '0; dm_ack = 0; dm_rdata = '0;
   endtask

   task automatic chk_regs_zero(string tag);
      chk({tag, ".rw"},  {31'd0, regwrite_out}, 32'd0);
      chk({tag, ".mtr"}, {31'd0, memtoreg_out}, 32'd0);
      chk({tag, ".rd"},  rdata_out, 32'd0);
      chk({tag, ".alu"}, alurslt_out, 32'd0);
      chk({tag, ".wr"},  {27'd0, wrreg_out}, 32'd0);
      chk({tag, ".mis"}, {31'd0, misalign}, 32'd0);
      chk({tag, ".be"},  {31'd0, bus_err}, 32'd0);
   endtask

   // kind: 0 alu, 1 load, 2 store, 3 read+write, 4 misaligned load, 5 branch
   // d: index of the request cycle that sees ack (>= TO means never)
   task automatic txn(int kind, int d);
      logic [31:0] a, ad;
      logic acc, rw, mtr, tmo, done;
      int k;
      a = $urandom();
      a[1:0] = (kind == 4) ? 2'($urandom_range(1, 3)) : 2'b00;
      rw  = 1'($urandom_range(0, 1));
      mtr = 1'($urandom_range(0, 1));
      acc = (kind >= 1 && kind <= 3);
      drive_idle();
      memread  = (kind == 1 || kind == 3 || kind == 4);
      memwrite = (kind == 2 || kind == 3);
      branch   = (kind == 5);
      zero     = 1'($urandom_range(0, 1));
      ad       = $urandom();
      baddr    = ad;
      alurslt  = a;
      data2    = $urandom();
      wrreg    = 5'($urandom_range(0, 31));
      regwrite = rw;
      memtoreg = mtr;
      tmo = acc && (d >= TO);
      k = 0;
      done = 0;
      while (!done) begin
         dm_ack   = acc && (k == d);
         dm_rdata = $urandom();
         @(negedge clk);
         chk("req", {31'd0, dm_req}, {31'd0, acc});
         chk("stall", {31'd0, stall},
             {31'd0, acc && k != d && k < TO - 1});
         chk("pcsrc", {31'd0, pcsrc}, {31'd0, branch & zero});
         chk("baddr", baddr_out, ad);
         if (acc) begin
            chk("we", {31'd0, dm_we}, {31'd0, kind != 1});
            chk("addr", dm_addr, a);
            chk("wdata", dm_wdata, data2);
         end
         if (acc && k == d) exp_rdata = dm_rdata;
         done = !acc || k == d || k == TO - 1;
         @(posedge clk); #1;
         if (!done) chk("bubble", {31'd0, regwrite_out}, 32'd0);
         k++;
      end
      chk("rw_out", {31'd0, regwrite_out},
          {31'd0, rw && !tmo && kind != 4});
      chk("mtr_out", {31'd0, memtoreg_out}, {31'd0, mtr});
      chk("alu_out", alurslt_out, a);
      chk("wr_out", {27'd0, wrreg_out}, {27'd0, wrreg});
      chk("rdata", rdata_out, exp_rdata);
      chk("bus_err", {31'd0, bus_err}, {31'd0, tmo});
      chk("misalign", {31'd0, misalign}, {31'd0, kind == 4});
      // a bubble cycle; after a timeout it carries a late ack
      drive_idle();
      dm_ack   = tmo;
      dm_rdata = $urandom();
      @(negedge clk);
      chk("idle_req", {31'd0, dm_req}, 32'd0);
      chk("idle_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("pulse_be", {31'd0, bus_err}, 32'd0);
      chk("pulse_mis", {31'd0, misalign}, 32'd0);
      chk("late_rd", rdata_out, exp_rdata);
   endtask

   initial begin
      drive_idle();
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      chk_regs_zero("reset");
      reset = 0;

      txn(0, 0);
      txn(1, 0);
      txn(1, 2);
      txn(2, 3);
      txn(3, 1);
      txn(1, 20);
      txn(1, TO - 1);
      txn(5, 0);
      txn(4, 0);
      for (int i = 0; i < 200; i++) begin
         int kd, dd;
         kd = $urandom_range(0, 5);
         dd = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 4)
                                          : $urandom_range(0, TO - 1);
         txn(kd, dd);
      end

      // reset while an access is outstanding
      drive_idle();
      memread  = 1;
      regwrite = 1;
      alurslt  = 32'h0000_0100;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_stall", {31'd0, stall}, 32'd1);
      reset = 1;
      drive_idle();
      @(posedge clk); #1;
      chk_regs_zero("midrst");
      chk("midrst.req", {31'd0, dm_req}, 32'd0);
      chk("midrst.stall", {31'd0, stall}, 32'd0);
      reset = 0;
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
